// File: rtl/adder_scheduler_if.sv
// Request/grant/result bundle between two clients and the shared nibble-serial adder.
// The scheduler takes the slave side; clients (or a bench) take the master side.
interface adder_scheduler_if #(
  parameter int W = 16
);
  logic         req0;
  logic         req1;
  logic [W-1:0] a0;
  logic [W-1:0] b0;
  logic [W-1:0] a1;
  logic [W-1:0] b1;
  logic         sub0;
  logic         sub1;
  logic         gnt0;
  logic         gnt1;
  logic         done0;
  logic         done1;
  logic [W-1:0] result;
  logic         cout;
  logic         ovf;
  logic         busy;

  modport master (
    output req0, req1, a0, b0, a1, b1, sub0, sub1,
    input  gnt0, gnt1, done0, done1, result, cout, ovf, busy
  );

  modport slave (
    input  req0, req1, a0, b0, a1, b1, sub0, sub1,
    output gnt0, gnt1, done0, done1, result, cout, ovf, busy
  );
endinterface

// File: rtl/adder_scheduler.sv
// Two-port round-robin scheduler around one 4-bit ripple adder; performs
// 4*NIBBLES-bit add/subtract one nibble per cycle with the carry registered.

module full_adder_4bit (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  output logic [3:0] s_o,
  output logic       cout_o
);
  logic c;

  // NOTE: blocking '=' is correct inside always_comb; every output gets a value
  // on every pass, so no latch is inferred.
  always_comb begin
    c = cin_i;
    s_o = 4'b0;
    for (int i = 0; i < 4; i++) begin
      s_o[i] = a_i[i] ^ b_i[i] ^ c;
      c      = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
    end
    cout_o = c;
  end
endmodule

module adder_scheduler #(
  parameter int NIBBLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  adder_scheduler_if.slave   bus
);
  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             port_q, port_d;
  logic             last_q, last_d;
  logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic             done0_q, done0_d, done1_q, done1_d;
  logic [W-1:0]     result_q, result_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [W-1:0]     a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic             sub_q, sub_d;

  logic             pick;
  logic [3:0]       add_b;
  logic [3:0]       add_s;
  logic             add_co;

  // Operands shift right each nibble, so the adder always sees bits [3:0].
  assign add_b = b_q[3:0] ^ {4{sub_q}};

  full_adder_4bit u_adder (
    .a_i    (a_q[3:0]),
    .b_i    (add_b),
    .cin_i  (carry_q),
    .s_o    (add_s),
    .cout_o (add_co)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    port_d   = port_q;
    last_d   = last_q;
    gnt0_d   = 1'b0;
    gnt1_d   = 1'b0;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    a_d      = a_q;
    b_d      = b_q;
    sub_d    = sub_q;
    acc_d    = acc_q;
    pick     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.req0 || bus.req1) begin
          // last_q names the port served most recently; the other one wins a tie.
          pick    = (bus.req0 && bus.req1) ? ~last_q : bus.req1;
          port_d  = pick;
          a_d     = pick ? bus.a1   : bus.a0;
          b_d     = pick ? bus.b1   : bus.b0;
          sub_d   = pick ? bus.sub1 : bus.sub0;
          carry_d = sub_d;
          idx_d   = '0;
          gnt0_d  = ~pick;
          gnt1_d  = pick;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d   = {add_s, acc_q[W-1:4]};
        a_d     = a_q >> 4;
        b_d     = b_q >> 4;
        carry_d = add_co;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d  = S_DONE;
          result_d = acc_d;
          cout_d   = add_co;
          ovf_d    = (a_q[3] == add_b[3]) && (add_s[3] != a_q[3]);
          done0_d  = ~port_q;
          done1_d  = port_q;
        end
      end
      S_DONE: begin
        last_d  = port_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking '<=' only, so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      port_q   <= 1'b0;
      last_q   <= 1'b1;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      port_q   <= port_d;
      last_q   <= last_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  // NOTE: operand and accumulator registers have no reset; they are always
  // loaded at grant before anything reads them.
  always_ff @(posedge clk) begin
    a_q   <= a_d;
    b_q   <= b_d;
    sub_q <= sub_d;
    acc_q <= acc_d;
  end

  assign bus.gnt0   = gnt0_q;
  assign bus.gnt1   = gnt1_q;
  assign bus.done0  = done0_q;
  assign bus.done1  = done1_q;
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
  assign bus.ovf    = ovf_q;
  assign bus.busy   = (state_q != S_IDLE);
endmodule
